// File: rtl/sprite_rom_arbiter.sv
// Round-robin, burst-aware arbiter sharing one single-port sprite ROM between
// the character, background and HUD fetchers; returns data in accept order.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 12,
    parameter int ROM_LATENCY = 2,
    parameter int MAX_BURST   = 4,
    parameter int BURST_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = ROM_LATENCY + 1;
    localparam logic [IDX_W-1:0]       LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(MAX_BURST);

    logic [IDX_W-1:0]       last_q,     last_d;
    logic [BURST_WIDTH-1:0] beat_q,     beat_d;
    logic                   rom_en_q,   rom_en_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0]     rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]  rd_data_q,  rd_data_d;
    logic                   tag_vld_q [DEPTH];
    logic [IDX_W-1:0]       tag_idx_q [DEPTH];

    logic                   cont_s;
    logic                   acc_s;
    logic [IDX_W-1:0]       gidx_s;
    logic [IDX_W:0]         pick_s;
    logic [NUM_REQ-1:0]     gnt_s;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Returns {valid, index}; scanning downward lets the nearest successor of last win.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] res;
        int             cand;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (r[cand]) begin
                res = {1'b1, IDX_W'(cand)};
            end
        end
        return res;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [NUM_REQ*ADDR_WIDTH-1:0] a,
                                                      input logic [IDX_W-1:0]              idx);
        logic [ADDR_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                res = a[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        return res;
    endfunction

    // Grant selection: continue the current burst, else round-robin from last+1.
    always_comb begin
        cont_s = 1'b0;
        pick_s = '0;
        acc_s  = 1'b0;
        gidx_s = last_q;
        if ((beat_q != '0) && (beat_q < BURST_MAX) && ((req & idx_to_onehot(last_q)) != '0)) begin
            cont_s = 1'b1;
        end else begin
            cont_s = 1'b0;
        end
        if (cont_s) begin
            acc_s  = 1'b1;
            gidx_s = last_q;
        end else begin
            pick_s = rr_pick(req, last_q);
            acc_s  = pick_s[IDX_W];
            gidx_s = pick_s[IDX_W-1:0];
        end
        if (acc_s) begin
            gnt_s = idx_to_onehot(gidx_s);
        end else begin
            gnt_s = '0;
        end
    end

    // Next-state for arbitration state, ROM issue and the return stage.
    always_comb begin
        last_d     = last_q;
        beat_d     = beat_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (acc_s) begin
            if ((gidx_s == last_q) && (beat_q != '0) && (beat_q < BURST_MAX)) begin
                beat_d = beat_q + BURST_WIDTH'(1);
            end else begin
                beat_d = BURST_WIDTH'(1);
            end
            last_d     = gidx_s;
            rom_en_d   = 1'b1;
            rom_addr_d = addr_of(req_addr, gidx_s);
        end else begin
            beat_d = '0;
        end
        if (tag_vld_q[DEPTH-1]) begin
            rd_valid_d = idx_to_onehot(tag_idx_q[DEPTH-1]);
            rd_data_d  = rom_data;
        end else begin
            rd_valid_d = '0;
        end
    end

    // Registered state; reset discards every in-flight read.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_q     <= LAST_RST;
            beat_q     <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            last_q       <= last_d;
            beat_q       <= beat_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            tag_vld_q[0] <= acc_s;
            tag_idx_q[0] <= gidx_s;
            for (int i = 1; i < DEPTH; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    assign gnt      = gnt_s;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a two-cycle-latency ROM model.
module tb_sprite_rom_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [41:0] req_addr;
    logic [2:0]  gnt;
    logic        rom_en;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic [2:0]  rd_valid;
    logic [11:0] rd_data;
    logic [11:0] rom_p1;
    logic [11:0] rom_p2;

    int total;
    int bad;

    localparam logic [13:0] A0 = 14'h0100;
    localparam logic [13:0] A1 = 14'h0201;
    localparam logic [13:0] A2 = 14'h0302;

    sprite_rom_arbiter #(
        .NUM_REQ(3), .ADDR_WIDTH(14), .DATA_WIDTH(12), .ROM_LATENCY(2), .MAX_BURST(4)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] rom_word(input logic [13:0] a);
        return a[11:0] ^ 12'h5A3;
    endfunction

    function automatic logic [2:0] oh(input int i);
        return 3'(1 << i);
    endfunction

    function automatic logic [13:0] addr_for(input int i);
        if (i == 0) return A0;
        else if (i == 1) return A1;
        else return A2;
    endfunction

    // ROM model: address sampled at the edge, data stable two cycles later.
    always @(posedge clk) begin
        rom_p1 <= rom_word(rom_addr);
        rom_p2 <= rom_p1;
    end
    assign rom_data = rom_p2;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 3'b000;
        req_addr = {A2, A1, A0};
        repeat (2) @(negedge clk);
        #1;
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b want=000", gnt); end
        total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%b want=0", rom_en); end
        total++; if (rom_addr !== 14'h0000) begin bad++; $display("FAIL reset_rom_addr got=%h want=0000", rom_addr); end
        total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL reset_rd_valid got=%b want=000", rd_valid); end
        total++; if (rd_data !== 12'h000) begin bad++; $display("FAIL reset_rd_data got=%h want=000", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req      = (c == 0) ? 3'b001 : 3'b000;
            req_addr = {A2, A1, 14'h0010};
            #1;
            if (c == 0) begin
                total++; if (gnt !== 3'b001) begin bad++; $display("FAIL single_gnt got=%b want=001", gnt); end
            end else begin
                total++; if (gnt !== 3'b000) begin bad++; $display("FAIL single_gnt_idle c=%0d got=%b want=000", c, gnt); end
            end
            if (c == 1) begin
                total++; if (rom_en !== 1'b1 || rom_addr !== 14'h0010) begin
                    bad++; $display("FAIL single_issue got en=%b addr=%h want en=1 addr=0010", rom_en, rom_addr); end
            end
            if (c == 2) begin
                total++; if (rom_en !== 1'b0 || rom_addr !== 14'h0010) begin
                    bad++; $display("FAIL single_hold got en=%b addr=%h want en=0 addr=0010", rom_en, rom_addr); end
            end
            if (c == 4) begin
                total++; if (rd_valid !== 3'b001 || rd_data !== rom_word(14'h0010)) begin
                    bad++; $display("FAIL single_return got v=%b d=%h want v=001 d=%h", rd_valid, rd_data, rom_word(14'h0010)); end
            end else begin
                total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL single_no_return c=%0d got=%b want=000", c, rd_valid); end
            end
        end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            req      = (c < 16) ? 3'b111 : 3'b000;
            req_addr = {A2, A1, A0};
            #1;
            g = (c / 4) % 3;
            if (c < 16) begin
                total++; if (gnt !== oh(g)) begin bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, oh(g)); end
            end
            if (c >= 4 && c < 20) begin
                g = ((c - 4) / 4) % 3;
                total++; if (rd_valid !== oh(g) || rd_data !== rom_word(addr_for(g))) begin
                    bad++; $display("FAIL rr_return c=%0d got v=%b d=%h want v=%b d=%h", c, rd_valid, rd_data, oh(g), rom_word(addr_for(g))); end
            end else begin
                total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL rr_quiet c=%0d got=%b want=000", c, rd_valid); end
            end
        end
    endtask

    task automatic test_owner_drop();
        int exp_seq [10] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req      = (c < 2) ? 3'b111 : 3'b110;
            req_addr = {A2, A1, A0};
            #1;
            total++; if (gnt !== oh(exp_seq[c])) begin
                bad++; $display("FAIL drop_gnt c=%0d got=%b want=%b", c, gnt, oh(exp_seq[c])); end
        end
        @(negedge clk);
        req = 3'b000;
    endtask

    task automatic test_single_owner();
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            req      = (c < 10) ? 3'b100 : 3'b000;
            req_addr = {A2, A1, A0};
            #1;
            if (c < 10) begin
                total++; if (gnt !== 3'b100) begin bad++; $display("FAIL solo_gnt c=%0d got=%b want=100", c, gnt); end
            end
            if (c >= 1) begin
                total++; if (rom_en !== 1'b1 || rom_addr !== A2) begin
                    bad++; $display("FAIL solo_issue c=%0d got en=%b addr=%h want en=1 addr=%h", c, rom_en, rom_addr, A2); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_addr = {A2, A1, (c == 0) ? 14'h0020 : 14'h0021};
            if (c < 2) begin
                req = 3'b001;
            end else if (c == 7) begin
                req = 3'b111;
            end else begin
                req = 3'b000;
            end
            if (c == 2) rst_n = 1'b0;
            if (c == 3) rst_n = 1'b1;
            #1;
            if (c == 2) begin
                total++; if (rom_en !== 1'b0 || rom_addr !== 14'h0000 || rd_data !== 12'h000) begin
                    bad++; $display("FAIL mid_reset_clear got en=%b addr=%h d=%h want 0/0000/000", rom_en, rom_addr, rd_data); end
            end
            if (c >= 2) begin
                total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL mid_reset_discard c=%0d got=%b want=000", c, rd_valid); end
            end
            if (c == 7) begin
                total++; if (gnt !== 3'b001) begin bad++; $display("FAIL mid_reset_first_gnt got=%b want=001", gnt); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  req_seq  [3] = '{3'b001, 3'b100, 3'b010};
        logic [2:0]  ret_seq  [3] = '{3'b001, 3'b100, 3'b010};
        logic [11:0] data_seq [3];
        data_seq[0] = rom_word(14'h0001);
        data_seq[1] = rom_word(14'h0002);
        data_seq[2] = rom_word(14'h0003);
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req      = (c < 3) ? req_seq[c] : 3'b000;
            req_addr = {14'h0002, 14'h0003, 14'h0001};
            #1;
            if (c < 3) begin
                total++; if (gnt !== req_seq[c]) begin bad++; $display("FAIL b2b_gnt c=%0d got=%b want=%b", c, gnt, req_seq[c]); end
            end
            if (c >= 4 && c < 7) begin
                total++; if (rd_valid !== ret_seq[c-4] || rd_data !== data_seq[c-4]) begin
                    bad++; $display("FAIL b2b_return c=%0d got v=%b d=%h want v=%b d=%h", c, rd_valid, rd_data, ret_seq[c-4], data_seq[c-4]); end
            end else if (c == 7) begin
                total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL b2b_tail got=%b want=000", rd_valid); end
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        req      = 3'b000;
        req_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_owner_drop();
        test_single_owner();
        test_reset_midflight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin, burst-aware arbiter that shares the single-port sprite ROM between the character renderer, background tile fetch and HUD fetch. Each requester presents a word address and receives tagged read data after a fixed latency. The renderer indexes its region of the ROM from the character display id. This block sits between the pixel-generation units and the sprite ROM and guarantees one access per cycle with bounded starvation.

## Interface
- NUM_REQ, 3, number of requesters (index 0 = character, 1 = background, 2 = HUD)
- ADDR_WIDTH, 14, ROM word-address width
- DATA_WIDTH, 12, ROM word width (RGB444)
- ROM_LATENCY, 2, cycles from ROM address presented to ROM data stable (≥1)
- MAX_BURST, 4, max consecutive grants to one requester while others wait (≥1)
- BURST_WIDTH, $clog2(MAX_BURST+1), beat-counter width
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester read request, level
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rom_en  out  1  ROM read enable, registered
- rom_addr  out  ADDR_WIDTH  ROM address, registered
- rom_data  in  DATA_WIDTH  ROM read data
- rd_valid  out  NUM_REQ  one-hot return strobe, registered
- rd_data  out  DATA_WIDTH  returned word, registered

## Operation
- Accept: requester i accepted in a cycle when req[i] && gnt[i]. At most one accept per cycle. gnt[i] never high without req[i]. gnt is all-zero when req is all-zero.
- State: last (index of last accepted requester), beat_cnt (consecutive accepts of last in current burst).
- cont = (beat_cnt != 0) && req[last] && (beat_cnt < MAX_BURST).
- Grant selection: if cont, grant last. Otherwise grant the first requesting index scanning last+1, last+2, …, wrapping mod NUM_REQ, ending at last itself (lowest priority).
- Update on accept of g: if g == last and beat_cnt != 0 and beat_cnt < MAX_BURST, beat_cnt += 1; else beat_cnt = 1. last = g.
- Update with no accept: beat_cnt = 0; last unchanged.
- Burst-limit case: beat_cnt == MAX_BURST with only last requesting, so last is re-granted with beat_cnt = 1. No idle bubble.
- Owner drop: if req[last] falls mid-burst, the round-robin pick is made in that same cycle. No bubble.
- Issue: on accept, rom_en = 1 and rom_addr = req_addr[g] next cycle. Otherwise rom_en = 0 and rom_addr holds its value.
- Return: tag pipeline (valid + index) of depth ROM_LATENCY+1 tracks each issue. rd_data captures rom_data in the cycle the ROM output is stable. rd_valid is a one-hot of the tag index, high for exactly one cycle per accept.
- Return order equals accept order. No reordering, no back-pressure: consumers must sink rd_valid every cycle.
- Reset values: last = NUM_REQ-1, so requester 0 wins first. beat_cnt = 0, rom_en = 0, rom_addr = 0, rd_valid = 0, rd_data = 0, tag pipeline cleared.
- Reset mid-operation: all in-flight reads are discarded and never produce rd_valid.

## Timing
- Accept in cycle T → rom_en/rom_addr in T+1 → rom_data stable in T+1+ROM_LATENCY → rd_valid/rd_data in T+2+ROM_LATENCY (T+4 at default).
- Throughput: one accept per cycle, sustained indefinitely.
- Starvation bound: a continuously requesting requester waits at most (NUM_REQ-1)*MAX_BURST cycles.
- gnt depends combinationally on req, last and beat_cnt only, never on req_addr.
- rd_valid is one-hot or zero every cycle.

## Test plan
- Reset, then req=3'b001, addr0=0x0010 in cycle T only → gnt=001 in T. rom_en=1, rom_addr=0x0010 in T+1. rd_valid=001, rd_data=ROM[0x0010] in T+4. All outputs 0 during reset.
- req=3'b111 held 16 cycles → gnt sequence 0,0,0,0,1,1,1,1,2,2,2,2,0,0,0,0. rd_valid follows the same sequence delayed 4 cycles.
- req0 drops after 2 beats while req1, req2 are high → third cycle gnt=010 with no gap. Burst of 4 on 1, then 4 on 2.
- Only req2 held 10 cycles → gnt=100 every cycle, rom_en continuously high. beat_cnt goes 1,2,3,4,1,2,…
- Accepts at T and T+1, sys_rst_n low in T+2 for one cycle → no rd_valid in T+4/T+5. After release with req=111, first gnt=001.
- Alternate accepts 0,2,1 with addresses 0x0001/0x0002/0x0003 → rd_valid 001,100,010 on consecutive cycles with the matching ROM words.
